// File: rtl/m_trigger.sv
// -----------------------------------------------------------------------------
// m_trigger
//   Capture-buffer write sequencer that sits behind m_finder. After an arm it
//   writes pre_count samples unconditionally (PRE), keeps writing while it
//   waits for a qualifying slope event (WAIT), marks the sample written in the
//   event cycle as the trigger sample, writes post_count further samples
//   (POST) and then parks in DONE until re-armed. The write pointer runs
//   modulo the buffer depth, so the buffer behaves as a ring.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   in          sample stream (m_finder output), aligned with positive/negative
//   positive    rising-slope event
//   negative    falling-slope event
//   arm         level; starts a capture when sampled high in IDLE or DONE
//   abort       level; returns the block to IDLE, beats arm and trigger
//   mode        00 positive, 01 negative, 10 either, 11 auto (either or timeout)
//   pre_count   samples written before events are accepted
//   post_count  samples written after the trigger sample
//   wr_en       buffer write strobe
//   wr_addr     buffer write address
//   wr_data     buffer write data (sample of the previous cycle)
//   trig_addr   address the trigger sample was written to
//   busy        high in PRE, WAIT, POST
//   done        high in DONE
//   forced      high in DONE when the trigger came from the auto timeout
// -----------------------------------------------------------------------------
module m_trigger #(
    parameter int WIDTH        = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int AUTO_TIMEOUT = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in,
    input  logic                  positive,
    input  logic                  negative,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] pre_count,
    input  logic [ADDR_WIDTH-1:0] post_count,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  forced
);

    // The phase counter has to reach both the largest pre/post count and the
    // auto timeout, whichever is bigger.
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CMAX  = (AUTO_TIMEOUT > DEPTH) ? AUTO_TIMEOUT : DEPTH;
    localparam int CNT_W = $clog2(CMAX) + 1;

    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_TMO   = CNT_W'(AUTO_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

    localparam logic [1:0] MODE_POS  = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_AUTO = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [1:0]              mode_l, mode_l_nx;
    logic [ADDR_WIDTH-1:0]   pre_l, pre_l_nx;
    logic [ADDR_WIDTH-1:0]   post_l, post_l_nx;
    logic                    fpend, fpend_nx;

    logic [ADDR_WIDTH-1:0]   wr_addr_nx;
    logic [WIDTH-1:0]        wr_data_nx;
    logic [ADDR_WIDTH-1:0]   trig_addr_nx;
    logic                    wr_en_nx, busy_nx, done_nx, forced_nx;

    logic                    hit;
    logic                    timeout;

    function automatic logic busy_state(input state_t s);
        return (s == ST_PRE) || (s == ST_WAIT) || (s == ST_POST);
    endfunction

    // Slope qualification against the mode latched at arm time.
    always_comb begin
        hit = 1'b0;
        case (mode_l)
            MODE_POS: hit = positive;
            MODE_NEG: hit = negative;
            default:  hit = positive | negative;
        endcase
    end

    assign timeout = (mode_l == MODE_AUTO) && (cnt == CNT_TMO);

    // Next-state and next-output logic. Every output is a register, so the
    // output values for the coming cycle are derived from state_nx.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        mode_l_nx    = mode_l;
        pre_l_nx     = pre_l;
        post_l_nx    = post_l;
        fpend_nx     = fpend;
        wr_addr_nx   = wr_addr;
        trig_addr_nx = trig_addr;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    mode_l_nx  = mode;
                    pre_l_nx   = pre_count;
                    post_l_nx  = post_count;
                    fpend_nx   = 1'b0;
                    cnt_nx     = '0;
                    wr_addr_nx = ADDR_ZERO;
                    state_nx   = (pre_count == ADDR_ZERO) ? ST_WAIT : ST_PRE;
                end
            end

            ST_PRE: begin
                wr_addr_nx = wr_addr + ADDR_ONE;
                if (cnt == CNT_W'(pre_l) - CNT_ONE) begin
                    cnt_nx   = '0;
                    state_nx = ST_WAIT;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            ST_WAIT: begin
                wr_addr_nx = wr_addr + ADDR_ONE;
                if (hit || timeout) begin
                    // The write happening in this cycle is the trigger sample;
                    // a real event beats a simultaneous timeout.
                    trig_addr_nx = wr_addr;
                    fpend_nx     = ~hit;
                    cnt_nx       = '0;
                    state_nx     = (post_l == ADDR_ZERO) ? ST_DONE : ST_POST;
                end else if (mode_l == MODE_AUTO) begin
                    // Only auto mode counts, so other modes can wait forever
                    // without the counter wrapping.
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            ST_POST: begin
                wr_addr_nx = wr_addr + ADDR_ONE;
                if (cnt == CNT_W'(post_l) - CNT_ONE) begin
                    cnt_nx   = '0;
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Abort overrides everything above except trig_addr, which keeps the
        // last recorded trigger position.
        if (abort) begin
            state_nx     = ST_IDLE;
            cnt_nx       = '0;
            fpend_nx     = 1'b0;
            wr_addr_nx   = wr_addr;
            trig_addr_nx = trig_addr;
        end

        wr_en_nx   = busy_state(state_nx);
        busy_nx    = busy_state(state_nx);
        done_nx    = (state_nx == ST_DONE);
        forced_nx  = (state_nx == ST_DONE) && fpend_nx;
        wr_data_nx = busy_state(state_nx) ? in : wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mode_l    <= '0;
            pre_l     <= '0;
            post_l    <= '0;
            fpend     <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            trig_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            forced    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mode_l    <= mode_l_nx;
            pre_l     <= pre_l_nx;
            post_l    <= post_l_nx;
            fpend     <= fpend_nx;
            wr_en     <= wr_en_nx;
            wr_addr   <= wr_addr_nx;
            wr_data   <= wr_data_nx;
            trig_addr <= trig_addr_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            forced    <= forced_nx;
        end
    end

endmodule

// File: tb/tb_m_trigger.sv
// -----------------------------------------------------------------------------
// tb_m_trigger
//   Directed bench for m_trigger (WIDTH=8, ADDR_WIDTH=4, AUTO_TIMEOUT=20).
//   Cycle 0 is the cycle in which arm is presented; cycle c is the cycle after
//   c rising edges. Every write of a capture is checked for a contiguous
//   address (mod 16) and for carrying the sample presented one cycle earlier.
// -----------------------------------------------------------------------------
module tb_m_trigger;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_s;
    logic       positive, negative, arm, abort;
    logic [1:0] mode;
    logic [3:0] pre_count, post_count;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] trig_addr;
    logic       busy, done, forced;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   nwr;
    logic [7:0] prev;

    m_trigger #(
        .WIDTH       (8),
        .ADDR_WIDTH  (4),
        .AUTO_TIMEOUT(20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_s),
        .positive  (positive),
        .negative  (negative),
        .arm       (arm),
        .abort     (abort),
        .mode      (mode),
        .pre_count (pre_count),
        .post_count(post_count),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .trig_addr (trig_addr),
        .busy      (busy),
        .done      (done),
        .forced    (forced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the edge, then the next
    // sample value is driven.
    task automatic tick();
        @(posedge clk);
        prev = in_s;
        #1;
        if (wr_en === 1'b1) begin
            chk("wr_addr_seq", {28'd0, wr_addr}, nwr[31:0] & 32'hF);
            chk("wr_data",     {24'd0, wr_data}, {24'd0, prev});
            nwr++;
        end
        in_s = in_s + 8'd37;
    endtask

    // Arm in cycle 0, then drive per-cycle masks for cycles 1..ncyc-1.
    // Returns positioned in cycle ncyc with all control inputs low.
    task automatic run(input logic [1:0] m, input logic [3:0] pr, input logic [3:0] po,
                       input logic [63:0] pm, input logic [63:0] nm,
                       input logic [63:0] am, input logic [63:0] bm, input int ncyc);
        mode       = m;
        pre_count  = pr;
        post_count = po;
        arm        = 1'b1;
        abort      = 1'b0;
        nwr        = 0;
        tick();
        arm = 1'b0;
        // Parameters are latched; scrambling them must not matter.
        mode       = ~m;
        pre_count  = ~pr;
        post_count = ~po;
        for (int c = 1; c < ncyc; c++) begin
            positive = pm[c];
            negative = nm[c];
            arm      = am[c];
            abort    = bm[c];
            tick();
        end
        positive = 1'b0;
        negative = 1'b0;
        arm      = 1'b0;
        abort    = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_s       = 8'h11;
        positive   = 1'b0;
        negative   = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        mode       = 2'b00;
        pre_count  = 4'd0;
        post_count = 4'd0;
        nwr        = 0;
        #12;
        chk("rst_wr_en",  {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_trig",   {28'd0, trig_addr}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_forced", {31'd0, forced}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Positive mode, pre 4, post 3, pulse in cycle 10 -> trigger addr 9.
        run(2'b00, 4'd4, 4'd3, 64'd1 << 10, 64'd0, 64'd0, 64'd0, 13);
        chk("t1_busy13", {31'd0, busy}, 32'd1);
        chk("t1_done13", {31'd0, done}, 32'd0);
        tick();
        chk("t1_done",   {31'd0, done}, 32'd1);
        chk("t1_busy",   {31'd0, busy}, 32'd0);
        chk("t1_wr_en",  {31'd0, wr_en}, 32'd0);
        chk("t1_trig",   {28'd0, trig_addr}, 32'd9);
        chk("t1_forced", {31'd0, forced}, 32'd0);
        chk("t1_nwr",    nwr, 32'd13);

        // Negative mode: negative in PRE (c2) and positives in WAIT ignored,
        // negative in cycle 9 triggers at addr 8.
        run(2'b01, 4'd4, 4'd3, (64'd1 << 6) | (64'd1 << 7), (64'd1 << 2) | (64'd1 << 9),
            64'd0, 64'd0, 12);
        chk("t2_busy12", {31'd0, busy}, 32'd1);
        tick();
        chk("t2_done",   {31'd0, done}, 32'd1);
        chk("t2_trig",   {28'd0, trig_addr}, 32'd8);
        chk("t2_nwr",    nwr, 32'd12);

        // Arm held in DONE re-arms; abort in PRE returns to IDLE, trig kept.
        mode = 2'b00; pre_count = 4'd3; post_count = 4'd1;
        arm  = 1'b1;
        nwr  = 0;
        tick();
        chk("rearm_busy",  {31'd0, busy}, 32'd1);
        chk("rearm_done",  {31'd0, done}, 32'd0);
        chk("rearm_addr",  {28'd0, wr_addr}, 32'd0);
        arm   = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abpre_busy",  {31'd0, busy}, 32'd0);
        chk("abpre_wr_en", {31'd0, wr_en}, 32'd0);
        chk("abpre_trig",  {28'd0, trig_addr}, 32'd8);

        // Auto mode timeout: WAIT starts cycle 3, 20th WAIT cycle is 22.
        run(2'b11, 4'd2, 4'd1, 64'd0, 64'd0, 64'd0, 64'd0, 23);
        chk("t3_busy23", {31'd0, busy}, 32'd1);
        chk("t3_forced23", {31'd0, forced}, 32'd0);
        tick();
        chk("t3_done",   {31'd0, done}, 32'd1);
        chk("t3_forced", {31'd0, forced}, 32'd1);
        chk("t3_trig",   {28'd0, trig_addr}, 32'd5);
        chk("t3_nwr",    nwr, 32'd23);

        // Same, but a real event on the timeout cycle wins.
        run(2'b11, 4'd2, 4'd1, 64'd1 << 22, 64'd0, 64'd0, 64'd0, 23);
        tick();
        chk("t3b_done",   {31'd0, done}, 32'd1);
        chk("t3b_forced", {31'd0, forced}, 32'd0);
        chk("t3b_trig",   {28'd0, trig_addr}, 32'd5);

        // Address wrap: pre 14, 5 WAIT cycles, trigger in cycle 20 at addr 3.
        run(2'b00, 4'd14, 4'd1, 64'd1 << 20, 64'd0, 64'd0, 64'd0, 21);
        chk("t4_busy21", {31'd0, busy}, 32'd1);
        tick();
        chk("t4_done",   {31'd0, done}, 32'd1);
        chk("t4_trig",   {28'd0, trig_addr}, 32'd3);
        chk("t4_nwr",    nwr, 32'd21);

        // pre 0, post 0, event in the first WAIT cycle: one write at addr 0.
        run(2'b10, 4'd0, 4'd0, 64'd0, 64'd1 << 1, 64'd0, 64'd0, 2);
        chk("t5_done",   {31'd0, done}, 32'd1);
        chk("t5_wr_en",  {31'd0, wr_en}, 32'd0);
        chk("t5_trig",   {28'd0, trig_addr}, 32'd0);
        chk("t5_nwr",    nwr, 32'd1);

        // Arm in POST ignored; abort+arm in POST -> IDLE, trig addr 3 kept.
        run(2'b00, 4'd2, 4'd5, 64'd1 << 4, 64'd0, (64'd1 << 5) | (64'd1 << 6),
            64'd1 << 6, 7);
        chk("t6_busy",   {31'd0, busy}, 32'd0);
        chk("t6_wr_en",  {31'd0, wr_en}, 32'd0);
        chk("t6_done",   {31'd0, done}, 32'd0);
        chk("t6_trig",   {28'd0, trig_addr}, 32'd3);
        chk("t6_nwr",    nwr, 32'd6);
        tick();
        chk("t6_idle",   {31'd0, busy}, 32'd0);

        // Reset pulse in WAIT takes effect immediately; no restart without arm.
        run(2'b00, 4'd1, 4'd1, 64'd0, 64'd0, 64'd0, 64'd0, 4);
        chk("t7_busy_wait", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_busy",  {31'd0, busy}, 32'd0);
        chk("t7_rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("t7_rst_addr",  {28'd0, wr_addr}, 32'd0);
        chk("t7_rst_trig",  {28'd0, trig_addr}, 32'd0);
        chk("t7_rst_data",  {24'd0, wr_data}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        tick();
        chk("t7_post_busy",  {31'd0, busy}, 32'd0);
        chk("t7_post_wr_en", {31'd0, wr_en}, 32'd0);
        chk("t7_post_done",  {31'd0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
